// File: rtl/assoc_cache_pkg.sv
// Shared types, constants and address-split helpers for the write-back set-associative cache.
package assoc_cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_EVICT_REQ,
        S_EVICT_WAIT,
        S_REFILL_REQ,
        S_REFILL_WAIT,
        S_RESPOND
    } state_e;

    localparam int unsigned REPL_FIFO = 0;
    localparam int unsigned REPL_PLRU = 1;

    function automatic int unsigned off_width(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned idx_width(input int unsigned set_count);
        return $clog2(set_count);
    endfunction

    function automatic int unsigned tag_width(input int unsigned line_words,
                                              input int unsigned set_count);
        return 30 - $clog2(line_words) - $clog2(set_count);
    endfunction

    function automatic int unsigned way_width(input int unsigned way_count);
        return $clog2(way_count);
    endfunction

    // Byte-lane merge of a core write into an existing word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/assoc_cache_plru.sv
// Tree pseudo-LRU for one set: path update for an accessed way and victim selection.
// Node 0 is the root, children of node n are 2n+1 / 2n+2; a bit value of 1 points right.
module assoc_cache_plru #(
    parameter int unsigned WAY_COUNT = 4
) (
    input  logic [WAY_COUNT-2:0]         plru_bits,
    input  logic [$clog2(WAY_COUNT)-1:0] access_way,
    output logic [WAY_COUNT-2:0]         next_bits,
    output logic [$clog2(WAY_COUNT)-1:0] victim_way
);
    localparam int unsigned LVL = $clog2(WAY_COUNT);

    // Walk the access path setting each node to point away from the accessed way.
    always_comb begin : p_update
        logic [LVL-1:0] node;
        logic           dir;
        next_bits = plru_bits;
        node      = '0;
        dir       = 1'b0;
        for (int unsigned l = 0; l < LVL; l++) begin
            dir             = access_way[LVL-1-l];
            next_bits[node] = ~dir;
            node            = LVL'(2 * 32'(node) + 1 + 32'(dir));
        end
    end

    // Follow the pointers from the root to the leaf that is least recently used.
    always_comb begin : p_victim
        logic [LVL-1:0] node;
        logic           dir;
        victim_way = '0;
        node       = '0;
        dir        = 1'b0;
        for (int unsigned l = 0; l < LVL; l++) begin
            dir                 = plru_bits[node];
            victim_way[LVL-1-l] = dir;
            node                = LVL'(2 * 32'(node) + 1 + 32'(dir));
        end
    end

endmodule

// File: rtl/assoc_cache_wb.sv
// Write-back, write-allocate set-associative cache between the core data port and the memory bus.
// One request in flight; dirty victims are written back word by word before a full-line refill.
module assoc_cache_wb
    import assoc_cache_pkg::*;
#(
    parameter int unsigned WAY_COUNT  = 4,
    parameter int unsigned SET_COUNT  = 64,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned REPL_MODE  = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        core_req_i,
    input  logic [31:0] core_addr_i,
    input  logic        core_we_i,
    input  logic [3:0]  core_be_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    output logic        core_error_o,
    output logic [31:0] core_rdata_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic        mem_error_i,
    input  logic [31:0] mem_rdata_i
);
    localparam int unsigned OFF = off_width(LINE_WORDS);
    localparam int unsigned IDX = idx_width(SET_COUNT);
    localparam int unsigned TAG = tag_width(LINE_WORDS, SET_COUNT);
    localparam int unsigned WB  = way_width(WAY_COUNT);
    localparam logic [OFF-1:0] LAST_WORD = OFF'(LINE_WORDS - 1);

    state_e         state_q;
    logic [29:0]    waddr_q;
    logic           we_q;
    logic [3:0]     be_q;
    logic [31:0]    wdata_q;
    logic [WB-1:0]  victim_q;
    logic [OFF-1:0] word_q;
    logic [31:0]    resp_word_q;

    logic [TAG-1:0]       tag_q   [SET_COUNT][WAY_COUNT];
    logic [WAY_COUNT-1:0] valid_q [SET_COUNT];
    logic [WAY_COUNT-1:0] dirty_q [SET_COUNT];
    logic [31:0]          data_q  [SET_COUNT][WAY_COUNT][LINE_WORDS];
    logic [WB-1:0]        fifo_q  [SET_COUNT];
    logic [WAY_COUNT-2:0] plru_q  [SET_COUNT];

    logic [OFF-1:0]       req_word, next_word;
    logic [IDX-1:0]       req_set;
    logic [TAG-1:0]       req_tag, victim_tag;
    logic                 hit, inv_found;
    logic [WB-1:0]        hit_way, inv_way, repl_victim, plru_victim, plru_access;
    logic [WAY_COUNT-2:0] plru_next;
    logic [31:0]          hit_data, refill_word;

    assign req_word    = waddr_q[OFF-1:0];
    assign req_set     = waddr_q[OFF+IDX-1:OFF];
    assign req_tag     = waddr_q[29:OFF+IDX];
    assign next_word   = word_q + OFF'(1);
    assign victim_tag  = tag_q[req_set][victim_q];
    assign hit_data    = data_q[req_set][hit_way][req_word];
    assign refill_word = (we_q && word_q == req_word) ? merge_bytes(mem_rdata_i, wdata_q, be_q)
                                                      : mem_rdata_i;
    assign plru_access = (state_q == S_LOOKUP) ? hit_way : victim_q;
    assign repl_victim = (REPL_MODE == REPL_PLRU) ? plru_victim : fifo_q[req_set];
    assign core_gnt_o  = reset_n && core_req_i && (state_q == S_IDLE);

    // Tag compare across the set, plus lowest invalid way for allocation.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < WAY_COUNT; w++) begin
            if (valid_q[req_set][w] && tag_q[req_set][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WB'(w);
            end
        end
        for (int unsigned w = WAY_COUNT; w > 0; w--) begin
            if (!valid_q[req_set][w-1]) begin
                inv_found = 1'b1;
                inv_way   = WB'(w - 1);
            end
        end
    end

    if (REPL_MODE == REPL_PLRU) begin : g_plru
        assoc_cache_plru #(.WAY_COUNT(WAY_COUNT)) u_plru (
            .plru_bits  (plru_q[req_set]),
            .access_way (plru_access),
            .next_bits  (plru_next),
            .victim_way (plru_victim)
        );
    end else begin : g_fifo
        assign plru_next   = plru_q[req_set];
        assign plru_victim = '0;
    end

    // Controller FSM with registered core/memory outputs and all cache state updates.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            waddr_q       <= '0;
            we_q          <= 1'b0;
            be_q          <= '0;
            wdata_q       <= '0;
            victim_q      <= '0;
            word_q        <= '0;
            resp_word_q   <= '0;
            core_rvalid_o <= 1'b0;
            core_error_o  <= 1'b0;
            core_rdata_o  <= '0;
            mem_req_o     <= 1'b0;
            mem_addr_o    <= '0;
            mem_we_o      <= 1'b0;
            mem_be_o      <= '0;
            mem_wdata_o   <= '0;
            for (int unsigned s = 0; s < SET_COUNT; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                fifo_q[s]  <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (core_gnt_o) begin
                        waddr_q <= core_addr_i[31:2];
                        we_q    <= core_we_i;
                        be_q    <= core_be_i;
                        wdata_q <= core_wdata_i;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        if (we_q) begin
                            data_q[req_set][hit_way][req_word] <= merge_bytes(hit_data, wdata_q, be_q);
                            dirty_q[req_set][hit_way]          <= 1'b1;
                            core_rdata_o                       <= '0;
                        end else begin
                            core_rdata_o <= hit_data;
                        end
                        plru_q[req_set] <= plru_next;
                        core_rvalid_o   <= 1'b1;
                        state_q         <= S_RESPOND;
                    end else begin
                        word_q <= '0;
                        if (inv_found) begin
                            victim_q <= inv_way;
                            state_q  <= S_REFILL_REQ;
                        end else begin
                            victim_q        <= repl_victim;
                            fifo_q[req_set] <= fifo_q[req_set] + WB'(1);
                            state_q         <= dirty_q[req_set][repl_victim] ? S_EVICT_REQ : S_REFILL_REQ;
                        end
                    end
                end
                S_EVICT_REQ: begin
                    if (!mem_req_o) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b1;
                        mem_be_o    <= 4'b1111;
                        mem_addr_o  <= {victim_tag, req_set, word_q, 2'b00};
                        mem_wdata_o <= data_q[req_set][victim_q][word_q];
                    end else if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state_q   <= S_EVICT_WAIT;
                    end
                end
                S_EVICT_WAIT: begin
                    if (mem_rvalid_i) begin
                        if (mem_error_i) begin
                            valid_q[req_set][victim_q] <= 1'b0;
                            dirty_q[req_set][victim_q] <= 1'b0;
                            core_rvalid_o              <= 1'b1;
                            core_error_o               <= 1'b1;
                            core_rdata_o               <= '0;
                            state_q                    <= S_RESPOND;
                        end else if (word_q == LAST_WORD) begin
                            // Issue refill word 0 straight away so eviction and refill are back to back.
                            dirty_q[req_set][victim_q] <= 1'b0;
                            word_q                     <= '0;
                            mem_req_o                  <= 1'b1;
                            mem_we_o                   <= 1'b0;
                            mem_be_o                   <= 4'b1111;
                            mem_addr_o                 <= {req_tag, req_set, {OFF{1'b0}}, 2'b00};
                            mem_wdata_o                <= '0;
                            state_q                    <= S_REFILL_REQ;
                        end else begin
                            word_q      <= next_word;
                            mem_req_o   <= 1'b1;
                            mem_addr_o  <= {victim_tag, req_set, next_word, 2'b00};
                            mem_wdata_o <= data_q[req_set][victim_q][next_word];
                            state_q     <= S_EVICT_REQ;
                        end
                    end
                end
                S_REFILL_REQ: begin
                    if (!mem_req_o) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_be_o    <= 4'b1111;
                        mem_addr_o  <= {req_tag, req_set, word_q, 2'b00};
                        mem_wdata_o <= '0;
                    end else if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state_q   <= S_REFILL_WAIT;
                    end
                end
                S_REFILL_WAIT: begin
                    if (mem_rvalid_i) begin
                        if (mem_error_i) begin
                            valid_q[req_set][victim_q] <= 1'b0;
                            dirty_q[req_set][victim_q] <= 1'b0;
                            core_rvalid_o              <= 1'b1;
                            core_error_o               <= 1'b1;
                            core_rdata_o               <= '0;
                            state_q                    <= S_RESPOND;
                        end else begin
                            // The pending write is merged as its word streams in, so the line lands final.
                            data_q[req_set][victim_q][word_q] <= refill_word;
                            if (!we_q && word_q == req_word) resp_word_q <= mem_rdata_i;
                            if (word_q == LAST_WORD) begin
                                valid_q[req_set][victim_q] <= 1'b1;
                                dirty_q[req_set][victim_q] <= we_q;
                                tag_q[req_set][victim_q]   <= req_tag;
                                plru_q[req_set]            <= plru_next;
                                core_rvalid_o              <= 1'b1;
                                core_rdata_o               <= we_q ? '0 :
                                                              ((word_q == req_word) ? mem_rdata_i : resp_word_q);
                                state_q                    <= S_RESPOND;
                            end else begin
                                word_q     <= next_word;
                                mem_req_o  <= 1'b1;
                                mem_addr_o <= {req_tag, req_set, next_word, 2'b00};
                                state_q    <= S_REFILL_REQ;
                            end
                        end
                    end
                end
                S_RESPOND: begin
                    core_rvalid_o <= 1'b0;
                    core_error_o  <= 1'b0;
                    core_rdata_o  <= '0;
                    state_q       <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
